// File: rtl/fp_multiplier_seq_pkg.sv
// Shared FPU constants and the result packer used by the sequential multiplier and divider.
// Packing is truncating: zero operands and underflow flush to 0, overflow saturates to infinity.
package fp_multiplier_seq_pkg;

    localparam int         FP_EXP_BIAS  = 127;
    localparam int         FP_MANT_W    = 23;
    localparam int         FP_MUL_STEPS = 24;
    localparam logic [7:0] FP_INF_EXP   = 8'hFF;

    function automatic logic [31:0] fp_pack(
        input logic                sign,
        input logic signed [9:0]   e1,
        input logic [FP_MANT_W-1:0] frac,
        input logic [7:0]          xe,
        input logic [7:0]          ye
    );
        logic [31:0] res;
        if (xe == 8'd0 || ye == 8'd0) begin
            res = 32'd0;
        end else if (e1 <= 10'sd0) begin
            res = 32'd0;
        end else if (e1 >= 10'sd255) begin
            res = {sign, FP_INF_EXP, {FP_MANT_W{1'b0}}};
        end else begin
            res = {sign, e1[7:0], frac};
        end
        return res;
    endfunction

endpackage

// File: rtl/fp_multiplier_seq.sv
// IEEE single multiplier: 24-step shift-add mantissa product, then combinational normalize/pack.
// Latency 24 enabled cycles from run; stall = run until done, enable=0 freezes all state.
module fp_multiplier_seq
    import fp_multiplier_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        run,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        stall,
    output logic [31:0] z
);

    localparam int STEPS = FP_MUL_STEPS;

    logic [4:0]  s;
    logic [47:0] p;

    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] my;
    logic [24:0] sum;
    logic [47:0] p_next;
    logic        done;

    assign done = (s == 5'(STEPS));

    // Step 0 seeds the low half with the multiplicand mantissa; its bits are consumed LSB first.
    always_comb begin
        a      = (s == 5'd0) ? 24'd0 : p[47:24];
        b      = (s == 5'd0) ? {1'b1, x[22:0]} : p[23:0];
        my     = {1'b1, y[22:0]};
        sum    = {1'b0, a} + (b[0] ? {1'b0, my} : 25'd0);
        p_next = {sum, b[23:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s <= 5'd0;
            p <= 48'd0;
        end else if (enable) begin
            if (!run) begin
                s <= 5'd0;
            end else if (!done) begin
                p <= p_next;
                s <= s + 5'd1;
            end
        end
    end

    logic signed [9:0]  e0;
    logic signed [9:0]  e1;
    logic [22:0]        frac;
    logic               sign;

    // Product of two [1,2) mantissas lies in [1,4); bit 47 selects the extra exponent step.
    always_comb begin
        e0   = signed'({2'b00, x[30:23]} + {2'b00, y[30:23]});
        sign = x[31] ^ y[31];
        if (p[47]) begin
            frac = p[46:24];
            e1   = e0 - 10'(FP_EXP_BIAS - 1);
        end else begin
            frac = p[45:23];
            e1   = e0 - 10'(FP_EXP_BIAS);
        end
    end

    assign stall = run & ~done;
    assign z     = done ? fp_pack(sign, e1, frac, x[30:23], y[30:23]) : 32'd0;

endmodule
